// File: rtl/execute_pkg.sv
// rtl/execute_pkg.sv - shared Y86-64 icode, ALU-function, condition and status codes
package execute_pkg;

  // Instruction codes
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Condition function codes shared by jXX and cmovXX
  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  // Highest legal ifunc for OPq and for jXX/cmovXX
  localparam logic [3:0] OPQ_FUNC_MAX  = 4'h3;
  localparam logic [3:0] COND_FUNC_MAX = 4'h6;

  // ALU operations; encoding matches the OPq ifunc low bits
  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } aluFunE;

  // Processor status
  typedef enum logic [1:0] {
    STAT_AOK = 2'd0,
    STAT_HLT = 2'd1,
    STAT_ADR = 2'd2,
    STAT_INS = 2'd3
  } statE;

  // Evaluate a jXX/cmovXX condition against {ZF,SF,OF}; unknown codes are false
  function automatic logic condHolds(input logic [3:0] ifunc, input logic zf,
                                     input logic sf, input logic of);
    logic lt;
    lt = sf ^ of;
    case (ifunc)
      C_YES:   condHolds = 1'b1;
      C_LE:    condHolds = lt | zf;
      C_L:     condHolds = lt;
      C_E:     condHolds = zf;
      C_NE:    condHolds = ~zf;
      C_GE:    condHolds = ~lt;
      C_G:     condHolds = ~lt & ~zf;
      default: condHolds = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/execute_alu.sv
// rtl/execute_alu.sv - combinational ALU computing aluB op aluA with flag outputs
module execute_alu
  import execute_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] aluA,
  input  logic [DATA_W-1:0] aluB,
  input  aluFunE            aluFun,
  output logic [DATA_W-1:0] result,
  output logic              zf,
  output logic              sf,
  output logic              of
);

  logic signA;
  logic signB;
  logic signR;

  assign signA = aluA[DATA_W-1];
  assign signB = aluB[DATA_W-1];
  assign signR = result[DATA_W-1];

  // Result and flags; arithmetic wraps, carry is discarded
  always_comb begin
    result = '0;
    of     = 1'b0;
    case (aluFun)
      ALU_ADD: begin
        result = aluB + aluA;
        of     = (signA == signB) && (signR != signA);
      end
      ALU_SUB: begin
        result = aluB - aluA;
        of     = (signA != signB) && (signR != signB);
      end
      ALU_AND: result = aluB & aluA;
      ALU_XOR: result = aluB ^ aluA;
      default: result = '0;
    endcase
    zf = (result == '0);
    sf = signR;
  end

endmodule

// File: rtl/execute.sv
// rtl/execute.sv - Y86-64 execute stage with condition codes and sticky status
module execute
  import execute_pkg::*;
#(
  parameter int         DATA_W     = 64,
  parameter int         STACK_STEP = 8,
  parameter logic [2:0] CC_RST     = 3'b100
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              en_i,
  input  logic [3:0]        icode_i,
  input  logic [3:0]        ifunc_i,
  input  logic [DATA_W-1:0] valC_i,
  input  logic [DATA_W-1:0] valA_i,
  input  logic [DATA_W-1:0] valB_i,
  input  logic              instr_valid_i,
  input  logic              imem_error_i,
  output logic [DATA_W-1:0] valE_o,
  output logic              cnd_o,
  output logic [2:0]        cc_o,
  output logic [1:0]        stat_o
);

  localparam logic [DATA_W-1:0] STEP = DATA_W'(STACK_STEP);

  logic [DATA_W-1:0] aluA;
  logic [DATA_W-1:0] aluB;
  aluFunE            aluFun;
  logic [DATA_W-1:0] aluResult;
  logic              aluZf;
  logic              aluSf;
  logic              aluOf;

  statE              statQ;
  statE              statD;
  statE              decStat;
  logic [2:0]        ccQ;
  logic [2:0]        ccD;
  logic              running;

  assign running = (statQ == STAT_AOK);

  // Operand and function selection per instruction class
  always_comb begin
    aluA   = '0;
    aluB   = '0;
    aluFun = ALU_ADD;
    case (icode_i)
      I_RRMOVQ: aluA = valA_i;
      I_IRMOVQ: aluA = valC_i;
      I_RMMOVQ, I_MRMOVQ: begin
        aluA = valC_i;
        aluB = valB_i;
      end
      I_OPQ: begin
        if (ifunc_i <= OPQ_FUNC_MAX) begin
          aluA   = valA_i;
          aluB   = valB_i;
          aluFun = aluFunE'(ifunc_i[1:0]);
        end
      end
      I_CALL, I_PUSHQ: begin
        aluA   = STEP;
        aluB   = valB_i;
        aluFun = ALU_SUB;
      end
      I_RET, I_POPQ: begin
        aluA = STEP;
        aluB = valB_i;
      end
      default: ;
    endcase
  end

  execute_alu #(
    .DATA_W (DATA_W)
  ) uAlu (
    .aluA   (aluA),
    .aluB   (aluB),
    .aluFun (aluFun),
    .result (aluResult),
    .zf     (aluZf),
    .sf     (aluSf),
    .of     (aluOf)
  );

  // Status of the instruction currently presented, highest priority first
  always_comb begin
    decStat = STAT_AOK;
    if (imem_error_i) begin
      decStat = STAT_ADR;
    end else if (!instr_valid_i
                 || (icode_i == I_OPQ && ifunc_i > OPQ_FUNC_MAX)
                 || ((icode_i == I_RRMOVQ || icode_i == I_JXX) && ifunc_i > COND_FUNC_MAX)) begin
      decStat = STAT_INS;
    end else if (icode_i == I_HALT) begin
      decStat = STAT_HLT;
    end
  end

  // Next status and CC: leave AOK only when enabled; CC updates on valid OPq only
  always_comb begin
    statD = statQ;
    ccD   = ccQ;
    if (en_i && running) begin
      statD = decStat;
      if (decStat == STAT_AOK && icode_i == I_OPQ) begin
        ccD = {aluZf, aluSf, aluOf};
      end
    end
  end

  // Status and condition-code registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      statQ <= STAT_AOK;
      ccQ   <= CC_RST;
    end else begin
      statQ <= statD;
      ccQ   <= ccD;
    end
  end

  // Outputs; a stopped processor produces no result and takes no branches
  always_comb begin
    valE_o = running ? aluResult : '0;
    cnd_o  = running && (icode_i == I_RRMOVQ || icode_i == I_JXX)
             && condHolds(ifunc_i, ccQ[2], ccQ[1], ccQ[0]);
    cc_o   = ccQ;
    stat_o = statQ;
  end

endmodule

// File: tb/tb_execute.sv
// tb/tb_execute.sv - directed self-checking bench for the execute stage
module tb_execute;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        en_i;
  logic [3:0]  icode_i;
  logic [3:0]  ifunc_i;
  logic [63:0] valC_i;
  logic [63:0] valA_i;
  logic [63:0] valB_i;
  logic        instr_valid_i;
  logic        imem_error_i;
  logic [63:0] valE_o;
  logic        cnd_o;
  logic [2:0]  cc_o;
  logic [1:0]  stat_o;

  int vectors = 0;
  int miscompares = 0;

  execute dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .en_i          (en_i),
    .icode_i       (icode_i),
    .ifunc_i       (ifunc_i),
    .valC_i        (valC_i),
    .valA_i        (valA_i),
    .valB_i        (valB_i),
    .instr_valid_i (instr_valid_i),
    .imem_error_i  (imem_error_i),
    .valE_o        (valE_o),
    .cnd_o         (cnd_o),
    .cc_o          (cc_o),
    .stat_o        (stat_o)
  );

  always #5 clk_i = ~clk_i;

  // Present one instruction, then let combinational outputs settle
  task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] c,
                       input logic [63:0] a, input logic [63:0] b);
    icode_i = ic;
    ifunc_i = fn;
    valC_i  = c;
    valA_i  = a;
    valB_i  = b;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n_i = 1'b0;
    #2;
    rst_n_i = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    en_i = 1'b1; instr_valid_i = 1'b1; imem_error_i = 1'b0;
    drive(4'h1, 4'h0, 64'h0, 64'h0, 64'h0);
    pulse_reset();
    vectors++;
    if (cc_o !== 3'b100) begin
      miscompares++; $display("FAIL reset_cc got %b want %b", cc_o, 3'b100);
    end
    vectors++;
    if (stat_o !== 2'd0) begin
      miscompares++; $display("FAIL reset_stat got %0d want 0", stat_o);
    end
    drive(4'h7, 4'h3, 64'h0, 64'h0, 64'h0);
    vectors++;
    if (cnd_o !== 1'b1) begin
      miscompares++; $display("FAIL reset_je got %b want 1", cnd_o);
    end
  endtask

  task automatic test_sub_zero();
    drive(4'h6, 4'h1, 64'h0, 64'd5, 64'd5);
    vectors++;
    if (valE_o !== 64'h0) begin
      miscompares++; $display("FAIL sub_valE got %h want 0", valE_o);
    end
    tick();
    vectors++;
    if (cc_o !== 3'b100) begin
      miscompares++; $display("FAIL sub_cc got %b want 100", cc_o);
    end
    drive(4'h7, 4'h4, 64'h0, 64'h0, 64'h0);
    vectors++;
    if (cnd_o !== 1'b0) begin
      miscompares++; $display("FAIL sub_jne got %b want 0", cnd_o);
    end
    drive(4'h7, 4'h1, 64'h0, 64'h0, 64'h0);
    vectors++;
    if (cnd_o !== 1'b1) begin
      miscompares++; $display("FAIL sub_jle got %b want 1", cnd_o);
    end
  endtask

  task automatic test_add_overflow();
    drive(4'h6, 4'h0, 64'h0, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000);
    vectors++;
    if (valE_o !== 64'h8000_0000_0000_0000) begin
      miscompares++; $display("FAIL add_valE got %h want 8000000000000000", valE_o);
    end
    tick();
    vectors++;
    if (cc_o !== 3'b011) begin
      miscompares++; $display("FAIL add_cc got %b want 011", cc_o);
    end
    drive(4'h7, 4'h2, 64'h0, 64'h0, 64'h0);
    vectors++;
    if (cnd_o !== 1'b0) begin
      miscompares++; $display("FAIL add_jl got %b want 0", cnd_o);
    end
    drive(4'h7, 4'h6, 64'h0, 64'h0, 64'h0);
    vectors++;
    if (cnd_o !== 1'b1) begin
      miscompares++; $display("FAIL add_jg got %b want 1", cnd_o);
    end
  endtask

  task automatic test_moves_and_stack();
    drive(4'hA, 4'h0, 64'h0, 64'h0, 64'h100);
    vectors++;
    if (valE_o !== 64'hF8) begin
      miscompares++; $display("FAIL push_valE got %h want f8", valE_o);
    end
    tick();
    vectors++;
    if (cc_o !== 3'b011) begin
      miscompares++; $display("FAIL push_cc got %b want 011", cc_o);
    end
    drive(4'hB, 4'h0, 64'h0, 64'h0, 64'hF8);
    vectors++;
    if (valE_o !== 64'h100) begin
      miscompares++; $display("FAIL pop_valE got %h want 100", valE_o);
    end
    drive(4'h8, 4'h0, 64'h0, 64'h0, 64'h0);
    vectors++;
    if (valE_o !== 64'hFFFF_FFFF_FFFF_FFF8) begin
      miscompares++; $display("FAIL call_wrap got %h want fffffffffffffff8", valE_o);
    end
    drive(4'h4, 4'h0, 64'h8, 64'h0, 64'h10);
    vectors++;
    if (valE_o !== 64'h18) begin
      miscompares++; $display("FAIL rmmov_valE got %h want 18", valE_o);
    end
    drive(4'h3, 4'h0, 64'h1234_5678, 64'h55, 64'h77);
    vectors++;
    if (valE_o !== 64'h1234_5678) begin
      miscompares++; $display("FAIL irmov_valE got %h want 12345678", valE_o);
    end
    drive(4'h2, 4'h1, 64'h0, 64'hABCD, 64'h77);
    vectors++;
    if (valE_o !== 64'hABCD) begin
      miscompares++; $display("FAIL rrmov_valE got %h want abcd", valE_o);
    end
    vectors++;
    if (cnd_o !== 1'b0) begin
      miscompares++; $display("FAIL cmovle got %b want 0", cnd_o);
    end
    drive(4'h1, 4'h0, 64'h0, 64'h1, 64'h2);
    vectors++;
    if (valE_o !== 64'h0 || cnd_o !== 1'b0) begin
      miscompares++; $display("FAIL nop_out got valE=%h cnd=%b want 0 0", valE_o, cnd_o);
    end
  endtask

  task automatic test_logic_ops();
    drive(4'h6, 4'h2, 64'h0, 64'hF0F0, 64'h3C3C);
    vectors++;
    if (valE_o !== 64'h3030) begin
      miscompares++; $display("FAIL and_valE got %h want 3030", valE_o);
    end
    tick();
    vectors++;
    if (cc_o !== 3'b000) begin
      miscompares++; $display("FAIL and_cc got %b want 000", cc_o);
    end
    drive(4'h6, 4'h1, 64'h0, 64'h1, 64'h8000_0000_0000_0000);
    vectors++;
    if (valE_o !== 64'h7FFF_FFFF_FFFF_FFFF) begin
      miscompares++; $display("FAIL subov_valE got %h want 7fffffffffffffff", valE_o);
    end
    tick();
    vectors++;
    if (cc_o !== 3'b001) begin
      miscompares++; $display("FAIL subov_cc got %b want 001", cc_o);
    end
    drive(4'h7, 4'h2, 64'h0, 64'h0, 64'h0);
    vectors++;
    if (cnd_o !== 1'b1) begin
      miscompares++; $display("FAIL subov_jl got %b want 1", cnd_o);
    end
  endtask

  task automatic test_halt();
    drive(4'h0, 4'h0, 64'h0, 64'h0, 64'h0);
    tick();
    vectors++;
    if (stat_o !== 2'd1) begin
      miscompares++; $display("FAIL halt_stat got %0d want 1", stat_o);
    end
    drive(4'h6, 4'h3, 64'h0, 64'h5, 64'h5);
    tick();
    vectors++;
    if (cc_o !== 3'b001) begin
      miscompares++; $display("FAIL halt_cc got %b want 001", cc_o);
    end
    drive(4'h6, 4'h0, 64'h0, 64'h1, 64'h2);
    vectors++;
    if (valE_o !== 64'h0) begin
      miscompares++; $display("FAIL halt_valE got %h want 0", valE_o);
    end
    drive(4'h7, 4'h0, 64'h0, 64'h0, 64'h0);
    vectors++;
    if (cnd_o !== 1'b0) begin
      miscompares++; $display("FAIL halt_jmp got %b want 0", cnd_o);
    end
    drive(4'h1, 4'h0, 64'h0, 64'h0, 64'h0);
    tick();
    vectors++;
    if (stat_o !== 2'd1) begin
      miscompares++; $display("FAIL halt_sticky got %0d want 1", stat_o);
    end
    rst_n_i = 1'b0;
    #1;
    vectors++;
    if (stat_o !== 2'd0 || cc_o !== 3'b100) begin
      miscompares++; $display("FAIL async_rst got stat=%0d cc=%b want 0 100", stat_o, cc_o);
    end
    rst_n_i = 1'b1;
    #1;
  endtask

  task automatic test_errors();
    imem_error_i = 1'b1; instr_valid_i = 1'b0;
    drive(4'h6, 4'h0, 64'h0, 64'h0, 64'h0);
    tick();
    vectors++;
    if (stat_o !== 2'd2) begin
      miscompares++; $display("FAIL adr_prio got %0d want 2", stat_o);
    end
    imem_error_i = 1'b0; instr_valid_i = 1'b1;
    pulse_reset();
    drive(4'h6, 4'h0, 64'h0, 64'h1, 64'h1);
    tick();
    vectors++;
    if (cc_o !== 3'b000) begin
      miscompares++; $display("FAIL pre_ins_cc got %b want 000", cc_o);
    end
    drive(4'h6, 4'h4, 64'h0, 64'h0, 64'h0);
    tick();
    vectors++;
    if (stat_o !== 2'd3 || cc_o !== 3'b000) begin
      miscompares++; $display("FAIL bad_opq got stat=%0d cc=%b want 3 000", stat_o, cc_o);
    end
    pulse_reset();
    drive(4'h2, 4'h7, 64'h0, 64'h0, 64'h0);
    tick();
    vectors++;
    if (stat_o !== 2'd3) begin
      miscompares++; $display("FAIL bad_cmov got %0d want 3", stat_o);
    end
    pulse_reset();
    instr_valid_i = 1'b0;
    drive(4'h1, 4'h0, 64'h0, 64'h0, 64'h0);
    tick();
    vectors++;
    if (stat_o !== 2'd3) begin
      miscompares++; $display("FAIL invalid_ins got %0d want 3", stat_o);
    end
    instr_valid_i = 1'b1;
    pulse_reset();
  endtask

  task automatic test_enable();
    en_i = 1'b0;
    drive(4'h0, 4'h0, 64'h0, 64'h0, 64'h0);
    tick();
    vectors++;
    if (stat_o !== 2'd0) begin
      miscompares++; $display("FAIL en_halt got %0d want 0", stat_o);
    end
    drive(4'h6, 4'h0, 64'h0, 64'h1, 64'h1);
    vectors++;
    if (valE_o !== 64'h2) begin
      miscompares++; $display("FAIL en_valE got %h want 2", valE_o);
    end
    tick();
    vectors++;
    if (cc_o !== 3'b100) begin
      miscompares++; $display("FAIL en_cc got %b want 100", cc_o);
    end
    en_i = 1'b1;
    tick();
    vectors++;
    if (cc_o !== 3'b000) begin
      miscompares++; $display("FAIL en_resume got %b want 000", cc_o);
    end
  endtask

  initial begin
    rst_n_i = 1'b1;
    en_i = 1'b0; instr_valid_i = 1'b1; imem_error_i = 1'b0;
    icode_i = 4'h1; ifunc_i = 4'h0; valC_i = '0; valA_i = '0; valB_i = '0;
    @(negedge clk_i);
    test_reset();
    test_sub_zero();
    test_add_overflow();
    test_moves_and_stack();
    test_logic_ops();
    test_halt();
    test_errors();
    test_enable();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
